// File: rtl/calc_keys_pkg.sv
// calc_keys_pkg: key codes shared by the keypad scanner and the calculator control FSM,
// plus the scanner state encoding.
package calc_keys_pkg;
    localparam logic [3:0] KEY_0     = 4'd0;
    localparam logic [3:0] KEY_1     = 4'd1;
    localparam logic [3:0] KEY_2     = 4'd2;
    localparam logic [3:0] KEY_3     = 4'd3;
    localparam logic [3:0] KEY_4     = 4'd4;
    localparam logic [3:0] KEY_5     = 4'd5;
    localparam logic [3:0] KEY_6     = 4'd6;
    localparam logic [3:0] KEY_7     = 4'd7;
    localparam logic [3:0] KEY_8     = 4'd8;
    localparam logic [3:0] KEY_9     = 4'd9;
    localparam logic [3:0] KEY_EQUAL = 4'd10;
    localparam logic [3:0] KEY_AC    = 4'd11;
    localparam logic [3:0] KEY_PLUS  = 4'd12;
    localparam logic [3:0] KEY_MINUS = 4'd13;
    localparam logic [3:0] KEY_MULT  = 4'd14;
    localparam logic [3:0] KEY_DIV   = 4'd15;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} scan_state_e;
endpackage

// File: rtl/keypad_keymap.sv
// keypad_keymap: maps a (row, column) keypad position to its 4-bit key code.
module keypad_keymap
    import calc_keys_pkg::*;
(
    input  logic [1:0] row_idx,
    input  logic [1:0] col_idx,
    output logic [3:0] code
);
    // Row-major: entry {row, col}
    localparam logic [3:0] MAP [16] = '{
        KEY_1,  KEY_2, KEY_3,     KEY_PLUS,
        KEY_4,  KEY_5, KEY_6,     KEY_MINUS,
        KEY_7,  KEY_8, KEY_9,     KEY_MULT,
        KEY_AC, KEY_0, KEY_EQUAL, KEY_DIV
    };

    assign code = MAP[{row_idx, col_idx}];
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces press and release,
// and emits one kbEN strobe with the encoded key per physical press.
module keypad_scanner
    import calc_keys_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 20000,
    parameter int PULSE_LEN    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] pressedkey,
    output logic       kbEN,
    output logic       busy
);
    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam int BW = $clog2(DEBOUNCE_CYC + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);

    scan_state_e   state, next;
    logic [3:0]    rs_meta, rs, cap, code;
    logic [1:0]    cidx, ridx;
    logic [DW-1:0] dwell;
    logic [BW-1:0] deb_cnt;
    logic [PW-1:0] pulse_cnt;
    logic          sample, hit, match, released, deb_done, pulse_done, adv;

    keypad_keymap u_keymap (.row_idx(ridx), .col_idx(cidx), .code(code));

    // Sampling in the last dwell cycle lets the 2-flop synchronizer settle on the new column
    assign sample     = dwell == DW'(SCAN_DIV - 1);
    assign hit        = $onehot(~rs);
    assign match      = rs == cap;
    assign released   = rs == 4'hF;
    assign deb_done   = deb_cnt == BW'(DEBOUNCE_CYC - 1);
    assign pulse_done = pulse_cnt == PW'(PULSE_LEN);
    assign adv        = (state == SCAN && sample && !hit) ||
                        (state == DEBOUNCE && !match) ||
                        (state == WAIT_RELEASE && released && deb_done);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= SCAN;
        else        state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            SCAN:         next = (sample && hit) ? DEBOUNCE : SCAN;
            DEBOUNCE:     next = !match ? SCAN : deb_done ? EMIT : DEBOUNCE;
            EMIT:         next = pulse_done ? WAIT_RELEASE : EMIT;
            WAIT_RELEASE: next = (released && deb_done) ? SCAN : WAIT_RELEASE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_meta    <= 4'hF;
            rs         <= 4'hF;
            cap        <= 4'hF;
            cidx       <= '0;
            ridx       <= '0;
            dwell      <= '0;
            deb_cnt    <= '0;
            pulse_cnt  <= '0;
            pressedkey <= '0;
        end else begin
            rs_meta   <= row;
            rs        <= rs_meta;
            cidx      <= adv ? cidx + 2'd1 : cidx;
            dwell     <= (state == SCAN && !sample) ? dwell + 1'b1 : '0;
            // One counter serves both press debounce and release debounce
            deb_cnt   <= ((state == DEBOUNCE && match) || (state == WAIT_RELEASE && released)) ?
                         deb_cnt + 1'b1 : '0;
            pulse_cnt <= (state == EMIT && !pulse_done) ? pulse_cnt + 1'b1 : '0;
            if (state == SCAN && sample && hit) begin
                cap  <= rs;
                ridx <= {~rs[3] | ~rs[2], ~rs[3] | ~rs[1]};
            end
            if (state == DEBOUNCE && match && deb_done) pressedkey <= code;
        end
    end

    // kbEN waits one EMIT cycle so pressedkey is already stable when it rises
    always_comb begin
        col  = ~(4'b0001 << cidx);
        kbEN = state == EMIT && pulse_cnt != '0;
        busy = state != SCAN;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad presses against a scoreboard of expected key codes.
module tb_keypad_scanner;
    import calc_keys_pkg::*;

    localparam int SD = 4;
    localparam int DC = 8;
    localparam int PL = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row, col, pressedkey;
    logic        kbEN, busy;
    logic [15:0] keys = '0;
    logic [3:0]  pk_q = '0;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          width = 0;
    int          exp_q[$];

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DC), .PULSE_LEN(PL)) dut (
        .clk(clk), .reset(reset), .row(row), .col(col),
        .pressedkey(pressedkey), .kbEN(kbEN), .busy(busy)
    );

    always #5 clk = ~clk;

    // Pressed key at (r, c) pulls row r low while column c is driven low
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_kb(input string tag, input int lim, output int n);
        n = 0;
        while (!kbEN && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(tag, kbEN, 1);
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int n = 0;
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, 0);
    endtask

    // Scoreboard side: each kbEN rise pops one expected code; width checked on fall
    always @(negedge clk) begin
        if (!reset) width = 0;
        else if (kbEN) begin
            if (width == 0) begin
                pulses++;
                chk("key_setup", pressedkey, pk_q);
                chk("pulse_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("pressedkey", pressedkey, exp_q.pop_front());
            end
            width++;
        end else if (width != 0) begin
            chk("pulse_width", width, PL);
            width = 0;
        end
        pk_q = pressedkey;
    end

    initial begin
        int n;
        logic [3:0] pc;
        logic [3:0] col_exp [5] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};

        cycles(3);
        chk("rst_col", col, 4'b1110);
        chk("rst_kben", kbEN, 0);
        chk("rst_key", pressedkey, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        cycles(5);

        // Clean '5'
        keys[1*4+1] = 1'b1;
        exp_q.push_back(KEY_5);
        wait_kb("kb_5", 40, n);
        chk("lat_5", n <= 27, 1);
        cycles(100);
        chk("pulses_5", pulses, 1);
        keys = '0;
        wait_idle("idle_5", 40);

        // Bouncy '+'
        cycles(5);
        for (int i = 0; i < 10; i++) begin
            keys[3] = ~keys[3];
            cycles(3);
        end
        chk("bounce_quiet", pulses, 1);
        keys[3] = 1'b1;
        exp_q.push_back(KEY_PLUS);
        wait_kb("kb_plus", 60, n);
        cycles(10);
        for (int i = 0; i < 6; i++) begin
            keys[3] = ~keys[3];
            cycles(3);
        end
        chk("rel_bounce_busy", busy, 1);
        keys[3] = 1'b0;
        cycles(7);
        chk("busy_hold", busy, 1);
        cycles(5);
        chk("busy_clear", busy, 0);
        chk("pulses_plus", pulses, 2);

        // Ghost: '1' and '4' share column 0
        keys = 16'h0011;
        n = 0;
        while (col !== 4'b1110 && n < 20) begin
            cycles(1);
            n++;
        end
        chk("ghost_sync", col, 4'b1110);
        for (int i = 0; i < 5; i++) begin
            pc = col;
            n = 0;
            while (col === pc && n < 2 * SD) begin
                cycles(1);
                n++;
            end
            chk("ghost_col", col, col_exp[i]);
            if (i > 0) chk("ghost_dwell", n, SD);
        end
        chk("ghost_nokb", pulses, 2);
        keys = '0;
        cycles(10);

        // '=' then 'AC'
        keys[3*4+2] = 1'b1;
        exp_q.push_back(KEY_EQUAL);
        wait_kb("kb_eq", 60, n);
        cycles(5);
        keys = '0;
        wait_idle("idle_eq", 40);
        cycles(20);
        keys[3*4+0] = 1'b1;
        exp_q.push_back(KEY_AC);
        wait_kb("kb_ac", 60, n);
        cycles(5);
        keys = '0;
        wait_idle("idle_ac", 40);
        cycles(100);
        chk("ac_hold", pressedkey, KEY_AC);
        chk("pulses_ac", pulses, 4);

        // Release glitch during debounce of '/'
        keys[3*4+3] = 1'b1;
        n = 0;
        while (!busy && n < 40) begin
            cycles(1);
            n++;
        end
        chk("div_debounce", busy, 1);
        cycles(4);
        keys[3*4+3] = 1'b0;
        wait_idle("glitch_abort", 10);
        chk("glitch_col", col, 4'b1110);
        chk("glitch_nokb", pulses, 4);
        cycles(5);
        keys[3*4+3] = 1'b1;
        exp_q.push_back(KEY_DIV);
        wait_kb("kb_div", 60, n);
        cycles(5);
        keys = '0;
        wait_idle("idle_div", 40);

        // Asynchronous reset in the middle of a strobe
        keys[2*4+2] = 1'b1;
        exp_q.push_back(KEY_9);
        wait_kb("kb_9", 60, n);
        #2 reset = 1'b0;
        #1;
        chk("arst_kben", kbEN, 0);
        chk("arst_key", pressedkey, 0);
        chk("arst_col", col, 4'b1110);
        chk("arst_busy", busy, 0);
        cycles(2);
        @(posedge clk);
        #2 reset = 1'b1;
        exp_q.push_back(KEY_9);
        wait_kb("kb_9_again", 60, n);
        cycles(20);
        keys = '0;
        wait_idle("idle_9", 40);
        cycles(5);
        chk("pulse_total", pulses, 7);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
